// File: rtl/psum_drain_if.sv
// psum_drain_if: control, psum memory read port and output stream of the psum drain engine.
interface psum_drain_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11
);
  logic                     start;
  logic                     relu_en;
  logic                     mem_cen;
  logic [addr_w-1:0]        mem_addr;
  logic [col*psum_bw-1:0]   mem_dout;
  logic [psum_bw-1:0]       out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     busy;
  logic                     done;
  modport slave (
    input  start, relu_en, mem_dout, out_ready,
    output mem_cen, mem_addr, out_data, out_valid, out_last, busy, done
  );
  modport master (
    output start, relu_en, mem_dout, out_ready,
    input  mem_cen, mem_addr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/psum_drain.sv
// psum_drain: reads psum rows 0..num_inp-1 and serialises them into psum_bw-bit words on a valid/ready stream.
module psum_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int num_inp = 64,
  parameter int addr_w  = 11
) (
  input  logic          clk,
  input  logic          reset,
  psum_drain_if.slave   bus
);
  localparam int WW = col > 1 ? $clog2(col) : 1;
  localparam int RW = addr_w + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t                 state_q, state_d;
  logic [RW-1:0]          rd_row_q, rd_row_d, erow_q, erow_d;
  logic [WW-1:0]          widx_q, widx_d;
  logic [addr_w-1:0]      addr_q;
  logic                   relu_q, relu_d, infl_q;
  logic [col*psum_bw-1:0] buf_q [2];
  logic [col*psum_bw-1:0] head;
  logic                   wp_q, rp_q;
  logic [1:0]             cnt_q, cnt_d;
  logic                   valid, issue, xfer, pop, last;
  logic [psum_bw-1:0]     word;
  assign valid = cnt_q != 2'd0;
  // in-flight read counts toward occupancy so the two-entry buffer never overflows
  assign issue = state_q == RUN && rd_row_q < RW'(num_inp) && ({1'b0, cnt_q} + {2'b0, infl_q}) < 3'd2;
  assign xfer  = valid && bus.out_ready;
  assign pop   = xfer && widx_q == WW'(col - 1);
  assign last  = valid && erow_q == RW'(num_inp - 1) && widx_q == WW'(col - 1);
  assign head  = buf_q[rp_q];
  assign word  = head[widx_q*psum_bw +: psum_bw];
  assign cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  always_comb begin
    state_d  = state_q;
    rd_row_d = issue ? rd_row_q + 1'b1 : rd_row_q;
    erow_d   = pop ? erow_q + 1'b1 : erow_q;
    widx_d   = xfer ? (pop ? '0 : widx_q + 1'b1) : widx_q;
    relu_d   = relu_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = RUN;
        rd_row_d = '0;
        erow_d   = '0;
        widx_d   = '0;
        relu_d   = bus.relu_en;
      end
      RUN:   state_d = issue && rd_row_q == RW'(num_inp - 1) ? FLUSH : RUN;
      FLUSH: state_d = last && bus.out_ready ? DONE : FLUSH;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_row_q <= '0;
      erow_q   <= '0;
      widx_q   <= '0;
      relu_q   <= 1'b0;
      infl_q   <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      rd_row_q <= rd_row_d;
      erow_q   <= erow_d;
      widx_q   <= widx_d;
      relu_q   <= relu_d;
      infl_q   <= issue;
      cnt_q    <= cnt_d;
      if (issue) addr_q <= rd_row_q[addr_w-1:0];
      if (infl_q) begin
        buf_q[wp_q] <= bus.mem_dout;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
    end
  end
  assign bus.mem_cen   = ~issue;
  assign bus.mem_addr  = issue ? rd_row_q[addr_w-1:0] : addr_q;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid && !(relu_q && word[psum_bw-1]) ? word : '0;
  assign bus.out_last  = last;
  assign bus.busy      = state_q == RUN || state_q == FLUSH;
  assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed and randomized drains of a 64-row and a 1-row engine against a queue-based word model.
module tb_psum_drain;
  localparam int COL = 8, BW = 16, AW = 11, NM = 64;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  psum_drain_if #(.col(COL), .psum_bw(BW), .addr_w(AW)) bm ();
  psum_drain_if #(.col(COL), .psum_bw(BW), .addr_w(AW)) bs ();
  psum_drain #(.col(COL), .psum_bw(BW), .num_inp(NM), .addr_w(AW)) dut_m (.clk(clk), .reset(reset), .bus(bm));
  psum_drain #(.col(COL), .psum_bw(BW), .num_inp(1), .addr_w(AW)) dut_s (.clk(clk), .reset(reset), .bus(bs));
  logic [COL*BW-1:0] mem_m [NM];
  logic [COL*BW-1:0] mem_s [1];
  always_ff @(posedge clk) if (!bm.mem_cen) bm.mem_dout <= mem_m[bm.mem_addr[5:0]];
  always_ff @(posedge clk) if (!bs.mem_cen) bs.mem_dout <= mem_s[0];
  logic sel = 1'b0, st = 1'b0, rl = 1'b0, rdy = 1'b0;
  assign bm.start = st & ~sel;
  assign bs.start = st & sel;
  assign bm.relu_en = rl;
  assign bs.relu_en = rl;
  assign bm.out_ready = rdy;
  assign bs.out_ready = rdy;
  logic c_valid, c_last, c_busy, c_done, c_cen;
  logic [BW-1:0] c_data;
  logic [AW-1:0] c_addr;
  always_comb begin
    c_valid = sel ? bs.out_valid : bm.out_valid;
    c_last  = sel ? bs.out_last  : bm.out_last;
    c_busy  = sel ? bs.busy      : bm.busy;
    c_done  = sel ? bs.done      : bm.done;
    c_cen   = sel ? bs.mem_cen   : bm.mem_cen;
    c_data  = sel ? bs.out_data  : bm.out_data;
    c_addr  = sel ? bs.mem_addr  : bm.mem_addr;
  end
  int checks = 0, errors = 0;
  logic [BW-1:0] expq [$];
  logic [BW-1:0] got [$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic build(input int rows, input bit relu);
    logic [COL*BW-1:0] row;
    logic [BW-1:0] w;
    expq.delete();
    for (int r = 0; r < rows; r++) begin
      row = sel ? mem_s[r] : mem_m[r];
      for (int k = 0; k < COL; k++) begin
        w = row[k*BW +: BW];
        expq.push_back(relu && $signed(w) < 0 ? '0 : w);
      end
    end
  endtask
  task automatic fill_basic();
    for (int r = 0; r < NM; r++)
      for (int k = 0; k < COL; k++) mem_m[r][k*BW +: BW] = BW'(r*COL + k);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cen"}, bm.mem_cen, 1);
    chk({tag, "_addr"}, bm.mem_addr, 0);
    chk({tag, "_valid"}, bm.out_valid, 0);
    chk({tag, "_data"}, bm.out_data, 0);
    chk({tag, "_last"}, bm.out_last, 0);
    chk({tag, "_busy"}, bm.busy, 0);
    chk({tag, "_done"}, bm.done, 0);
  endtask
  task automatic drain(input bit relu, input int rdy_pct, input int dbl_at, input int abort_at);
    int rows, total, nx, issued, ndone, cyc, last_cyc;
    bit stalled, fire;
    logic [BW-1:0] pdata;
    rows = sel ? 1 : NM;
    build(rows, relu);
    total = expq.size();
    got.delete();
    nx = 0; issued = 0; ndone = 0; cyc = 0; last_cyc = -10; stalled = 0; pdata = '0;
    @(negedge clk);
    st = 1'b1; rl = relu;
    @(negedge clk);
    st = 1'b0; rl = ~relu;
    chk("busy_after_start", c_busy, 1);
    while (ndone == 0 && cyc < 5000) begin
      if (cyc < 3) chk("first_valid", c_valid, cyc == 2);
      if (stalled) begin
        chk("stall_valid", c_valid, 1);
        chk("stall_data", c_data, pdata);
      end
      if (!c_cen) begin
        chk("rd_addr", c_addr, issued);
        issued++;
        chk("read_ahead", (issued - nx/COL) <= 2, 1);
      end
      if (c_done) begin
        ndone++;
        chk("done_count", nx, total);
        chk("done_busy", c_busy, 0);
        chk("done_timing", last_cyc, cyc - 1);
      end
      st = dbl_at > 0 && cyc == dbl_at;
      rdy = $urandom_range(99) < rdy_pct;
      fire = c_valid && rdy;
      if (c_valid) chk("out_last", c_last, nx == total - 1);
      if (fire) begin
        chk("data", c_data, expq[nx]);
        got.push_back(c_data);
        nx++;
        last_cyc = cyc;
      end
      stalled = c_valid && !rdy;
      pdata = c_data;
      if (abort_at > 0 && nx == abort_at) break;
      @(negedge clk);
      cyc++;
    end
    st = 1'b0;
    if (abort_at > 0) begin
      @(posedge clk);
      #3 reset = 1'b0;
      #1 check_reset_outputs("abort");
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (bm.done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      reset = 1'b1;
    end else begin
      chk("done_seen", ndone, 1);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (c_done) ndone++;
        if (!c_cen) issued++;
      end
      chk("one_done", ndone, 1);
      chk("idle_busy", c_busy, 0);
      chk("total_reads", issued, rows);
      chk("total_words", nx, total);
    end
    rdy = 1'b0;
  endtask
  logic [BW-1:0] relu_row [COL];
  logic [BW-1:0] relu_exp [COL];
  initial begin
    relu_row = '{16'hFFFB, 16'h0003, 16'h8000, 16'h0000, 16'h0007, 16'hFFFF, 16'h0002, 16'h7FFF};
    relu_exp = '{16'h0000, 16'h0003, 16'h0000, 16'h0000, 16'h0007, 16'h0000, 16'h0002, 16'h7FFF};
    fill_basic();
    mem_s[0] = '0;
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drain(1'b0, 100, 0, 0);
    chk("basic_last_val", got[NM*COL-1], NM*COL-1);
    for (int k = 0; k < COL; k++) mem_m[0][k*BW +: BW] = relu_row[k];
    drain(1'b1, 100, 0, 0);
    for (int k = 0; k < COL; k++) chk("relu_on", got[k], relu_exp[k]);
    drain(1'b0, 100, 0, 0);
    for (int k = 0; k < COL; k++) chk("relu_off", got[k], relu_row[k]);
    fill_basic();
    drain(1'b0, 50, 0, 0);
    drain(1'b0, 100, 200, 0);
    drain(1'b0, 100, 0, 100);
    drain(1'b0, 100, 0, 0);
    chk("restart_first", got[0], 0);
    for (int r = 0; r < NM; r++) mem_m[r] = {$urandom, $urandom, $urandom, $urandom};
    drain(1'($urandom_range(1)), 50, 0, 0);
    sel = 1'b1;
    mem_s[0] = {$urandom, $urandom, $urandom, $urandom};
    drain(1'b0, 100, 0, 0);
    drain(1'b1, 50, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
